// File: rtl/psum_accum_mem.sv
// Partial-sum memory with in-place read-modify-write accumulation.
// Stage 1 holds the captured request plus the old entry value (old_q).
// The next edge writes the combinational lane sums back into the array.
// Back-to-back hits on the same entry take the pending sum instead of the
// stale array word, so accumulation never stalls.
module psum_accum_mem #(
  parameter int psum_bw    = 16,
  parameter int col        = 8,
  parameter int addr_width = 8,
  parameter int SAT        = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [addr_width-1:0]     in_addr,
  input  logic [psum_bw*col-1:0]    in_data,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic                      relu_en,
  input  logic                      rd_req,
  output logic                      rd_ready,
  input  logic [addr_width-1:0]     rd_addr,
  output logic                      rd_valid,
  output logic [psum_bw*col-1:0]    rd_data,
  output logic                      busy,
  output logic                      sat_flag,
  input  logic                      clr_sat
);

  localparam int W     = psum_bw * col;
  localparam int DEPTH = 1 << addr_width;

  // Entry storage, deliberately not reset.
  logic [W-1:0]            mem_q [DEPTH];

  // Stage-1 request and the old entry value it will combine with.
  logic                    s1_valid_q;
  logic [addr_width-1:0]   s1_addr_q;
  logic [W-1:0]            s1_data_q;
  logic                    s1_first_q;
  logic                    s1_last_q;
  logic                    s1_relu_q;
  logic [W-1:0]            old_q;

  logic [W-1:0]            sum_d;
  logic [col-1:0]          lane_ovf_d;
  logic                    fwd_hit_d;
  logic                    sat_flag_q;
  logic                    sat_flag_d;
  logic                    rd_valid_q;
  logic [W-1:0]            rd_data_q;
  logic                    rd_grant_d;

  // Per-lane add with overflow detect, optional clamp, then ReLU.
  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    logic [psum_bw-1:0] a_d;
    logic [psum_bw-1:0] b_d;
    logic [psum_bw:0]   ext_d;
    logic [psum_bw-1:0] val_d;
    logic               ovf_d;

    // Overflow is judged on the true (one-bit-wider) sum, before any clamp.
    always_comb begin
      a_d   = old_q[gi*psum_bw +: psum_bw];
      b_d   = s1_data_q[gi*psum_bw +: psum_bw];
      ext_d = {a_d[psum_bw-1], a_d} + {b_d[psum_bw-1], b_d};
      ovf_d = 1'b0;
      val_d = ext_d[psum_bw-1:0];
      if (s1_first_q) begin
        val_d = b_d;
      end else begin
        ovf_d = ext_d[psum_bw] ^ ext_d[psum_bw-1];
        if (ovf_d && (SAT != 0)) begin
          val_d = ext_d[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                 : {1'b0, {(psum_bw-1){1'b1}}};
        end
      end
      if (s1_last_q && s1_relu_q && val_d[psum_bw-1]) begin
        val_d = '0;
      end
    end

    assign sum_d[gi*psum_bw +: psum_bw] = val_d;
    assign lane_ovf_d[gi]               = ovf_d;
  end

  assign fwd_hit_d  = s1_valid_q && (s1_addr_q == in_addr);
  assign rd_ready   = !in_valid && !s1_valid_q;
  assign rd_grant_d = rd_req && rd_ready;
  assign sat_flag_d = (sat_flag_q && !clr_sat) || (s1_valid_q && (|lane_ovf_d));

  assign in_ready = 1'b1;
  assign busy     = s1_valid_q;
  assign sat_flag = sat_flag_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // Datapath: write back stage 1, capture new request and its old value.
  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      mem_q[s1_addr_q] <= sum_d;
    end
    if (in_valid) begin
      s1_addr_q  <= in_addr;
      s1_data_q  <= in_data;
      s1_first_q <= in_first;
      s1_last_q  <= in_last;
      s1_relu_q  <= relu_en;
      old_q      <= fwd_hit_d ? sum_d : mem_q[in_addr];
    end
  end

  // Control state: pipeline valid, readout handshake and sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      rd_valid_q <= rd_grant_d;
      sat_flag_q <= sat_flag_d;
      if (rd_grant_d) begin
        rd_data_q <= mem_q[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_mem.sv
// Self-checking bench for psum_accum_mem: a saturating and a wrapping
// instance share all inputs; results are compared against table constants
// and against an integer-arithmetic model of each entry.
module tb_psum_accum_mem;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_addr;
  logic [127:0] in_data;
  logic         in_first, in_last, relu_en;
  logic         rd_req;
  logic [7:0]   rd_addr;
  logic         clr_sat;

  logic         in_ready_s, rd_ready_s, rd_valid_s, busy_s, sat_flag_s;
  logic [127:0] rd_data_s;
  logic         in_ready_w, rd_ready_w, rd_valid_w, busy_w, sat_flag_w;
  logic [127:0] rd_data_w;

  int checks = 0;
  int errors = 0;

  int m_sat  [256][8];
  int m_wrap [256][8];
  bit mflag_s = 1'b0;
  bit mflag_w = 1'b0;

  always #5 clk = ~clk;

  psum_accum_mem #(.psum_bw(16), .col(8), .addr_width(8), .SAT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_addr(in_addr), .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .relu_en(relu_en), .rd_req(rd_req), .rd_ready(rd_ready_s), .rd_addr(rd_addr),
    .rd_valid(rd_valid_s), .rd_data(rd_data_s), .busy(busy_s),
    .sat_flag(sat_flag_s), .clr_sat(clr_sat)
  );

  psum_accum_mem #(.psum_bw(16), .col(8), .addr_width(8), .SAT(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_addr(in_addr), .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .relu_en(relu_en), .rd_req(rd_req), .rd_ready(rd_ready_w), .rd_addr(rd_addr),
    .rd_valid(rd_valid_w), .rd_data(rd_data_w), .busy(busy_w),
    .sat_flag(sat_flag_w), .clr_sat(clr_sat)
  );

  typedef struct {
    int addr;
    int d0;
    int drest;
    bit first;
    bit last;
    bit relu;
    int exp0_s;
    int exp0_w;
    int exprest;
    bit exp_flag;
  } row_t;

  row_t rows [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane(input logic [127:0] v, input int l);
    logic [15:0] t;
    t = v[l*16 +: 16];
    return int'($signed(t));
  endfunction

  function automatic logic [127:0] fill(input int d0, input int drest);
    logic [127:0] r;
    int v;
    for (int l = 0; l < 8; l++) begin
      v = (l == 0) ? d0 : drest;
      r[l*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  function automatic int wrap16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // Reference: apply the currently driven request to both model memories.
  task automatic model_apply();
    int a, d, ts, tw, vs, vw;
    a = int'(in_addr);
    for (int l = 0; l < 8; l++) begin
      d = lane(in_data, l);
      if (in_first) begin
        vs = d;
        vw = d;
      end else begin
        ts = m_sat[a][l] + d;
        tw = m_wrap[a][l] + d;
        if (ts > 32767 || ts < -32768) mflag_s = 1'b1;
        if (tw > 32767 || tw < -32768) mflag_w = 1'b1;
        vs = (ts > 32767) ? 32767 : (ts < -32768) ? -32768 : ts;
        vw = wrap16(tw);
      end
      if (in_last && relu_en) begin
        if (vs < 0) vs = 0;
        if (vw < 0) vw = 0;
      end
      m_sat[a][l]  = vs;
      m_wrap[a][l] = vw;
    end
  endtask

  task automatic drive_op(input int a, input logic [127:0] d,
                          input bit f, input bit l, input bit r);
    in_valid = 1'b1;
    in_addr  = a[7:0];
    in_data  = d;
    in_first = f;
    in_last  = l;
    relu_en  = r;
    model_apply();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Bounded readout handshake; rd_data stays latched afterwards.
  task automatic read_grant(input int a, input string tag);
    int n;
    in_valid = 1'b0;
    rd_req   = 1'b1;
    rd_addr  = a[7:0];
    #1;
    n = 0;
    while (!rd_ready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " rd_ready"}, int'(rd_ready_s), 1);
    @(negedge clk);
    chk({tag, " rd_valid_s"}, int'(rd_valid_s), 1);
    chk({tag, " rd_valid_w"}, int'(rd_valid_w), 1);
    rd_req = 1'b0;
    @(negedge clk);
    chk({tag, " rd_valid pulse"}, int'(rd_valid_s), 0);
  endtask

  task automatic model_check_entry(input int a, input string tag);
    for (int l = 0; l < 8; l++) begin
      chk($sformatf("%s a%0d lane%0d sat", tag, a, l), lane(rd_data_s, l), m_sat[a][l]);
      chk($sformatf("%s a%0d lane%0d wrap", tag, a, l), lane(rd_data_w, l), m_wrap[a][l]);
    end
  endtask

  task automatic clr_pulse();
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    mflag_s = 1'b0;
    mflag_w = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit written [16];
    int a;
    logic [127:0] d;
    logic [15:0]  r16;

    reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    in_first = 1'b0; in_last = 1'b0; relu_en = 1'b0;
    rd_req = 1'b0; rd_addr = '0; clr_sat = 1'b0;

    rows[0] = '{5,   100,   100, 1, 0, 0,    100,    100, 100, 0};
    rows[1] = '{5,    20,    20, 0, 0, 0,    120,    120, 120, 0};
    rows[2] = '{7, 32000,     0, 1, 0, 0,  32000,  32000,   0, 0};
    rows[3] = '{7,  1000,     0, 0, 0, 0,  32767, -32536,   0, 1};
    rows[4] = '{8, -32000,    0, 1, 0, 0, -32000, -32000,   0, 0};
    rows[5] = '{8, -1000,     0, 0, 0, 0, -32768,  32536,   0, 1};
    rows[6] = '{10,  -50,    30, 1, 1, 1,      0,      0,  30, 0};
    rows[7] = '{11,  -50,    30, 1, 1, 0,    -50,    -50,  30, 0};
    rows[8] = '{12,  -20,    10, 1, 0, 0,    -20,    -20,  10, 0};
    rows[9] = '{12,  -30,     5, 0, 1, 1,      0,      0,  15, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", int'(in_ready_s), 1);
    chk("rst busy", int'(busy_s), 0);
    chk("rst rd_valid", int'(rd_valid_s), 0);
    chk("rst rd_data", lane(rd_data_s, 0), 0);
    chk("rst sat_flag", int'(sat_flag_s), 0);
    chk("rst rd_ready", int'(rd_ready_s), 1);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven single ops followed by readout
    for (int i = 0; i < 10; i++) begin
      drive_op(rows[i].addr, fill(rows[i].d0, rows[i].drest),
               rows[i].first, rows[i].last, rows[i].relu);
      idle(2);
      read_grant(rows[i].addr, $sformatf("row%0d", i));
      chk($sformatf("row%0d lane0 sat", i), lane(rd_data_s, 0), rows[i].exp0_s);
      chk($sformatf("row%0d lane0 wrap", i), lane(rd_data_w, 0), rows[i].exp0_w);
      chk($sformatf("row%0d lane7 sat", i), lane(rd_data_s, 7), rows[i].exprest);
      chk($sformatf("row%0d lane1 wrap", i), lane(rd_data_w, 1), rows[i].exprest);
      chk($sformatf("row%0d sat_flag_s", i), int'(sat_flag_s), int'(rows[i].exp_flag));
      chk($sformatf("row%0d sat_flag_w", i), int'(sat_flag_w), int'(rows[i].exp_flag));
      clr_pulse();
      chk($sformatf("row%0d clr sat_flag", i), int'(sat_flag_s), 0);
    end

    // clr_sat on the same edge as a set: the set wins
    drive_op(6, fill(32767, 0), 1, 0, 0);
    idle(2);
    drive_op(6, fill(1, 0), 0, 0, 0);
    in_valid = 1'b0;
    clr_sat  = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    chk("set-wins sat_flag_s", int'(sat_flag_s), 1);
    chk("set-wins sat_flag_w", int'(sat_flag_w), 1);
    clr_pulse();
    chk("set-wins clr", int'(sat_flag_s), 0);

    // Forwarding: three back-to-back ops to one entry
    drive_op(9, fill(10, 0), 1, 0, 0);
    drive_op(9, fill(5, 0), 0, 0, 0);
    drive_op(9, fill(7, 0), 0, 0, 0);
    in_valid = 1'b0;
    #1;
    chk("fwd busy held", int'(busy_s), 1);
    @(negedge clk);
    chk("fwd busy clear", int'(busy_s), 0);
    read_grant(9, "fwd");
    chk("fwd lane0", lane(rd_data_s, 0), 22);
    for (int l = 1; l < 8; l++) chk($sformatf("fwd lane%0d", l), lane(rd_data_s, l), 0);

    // Arbitration: held rd_req is refused while the stream or stage 1 is busy
    rd_req  = 1'b1;
    rd_addr = 8'd20;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_addr  = 8'd20;
      in_data  = fill((k == 0) ? 4 : k, (k == 0) ? 4 : k);
      in_first = (k == 0);
      in_last  = 1'b0;
      relu_en  = 1'b0;
      model_apply();
      #1;
      chk($sformatf("arb rd_ready op%0d", k), int'(rd_ready_s), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("arb rd_ready busy", int'(rd_ready_s), 0);
    @(negedge clk);
    chk("arb rd_ready free", int'(rd_ready_s), 1);
    chk("arb rd_valid early", int'(rd_valid_s), 0);
    @(negedge clk);
    chk("arb rd_valid grant", int'(rd_valid_s), 1);
    for (int l = 0; l < 8; l++) chk($sformatf("arb lane%0d", l), lane(rd_data_s, l), 10);
    rd_req = 1'b0;
    @(negedge clk);
    chk("arb rd_valid pulse", int'(rd_valid_s), 0);

    // Reset mid-operation discards the stage-1 write
    drive_op(4, fill(32767, 0), 1, 0, 0);
    drive_op(4, fill(1, 0), 0, 0, 0);
    idle(2);
    chk("pre-rst sat_flag", int'(sat_flag_s), 1);
    drive_op(3, fill(40, 40), 1, 0, 0);
    idle(2);
    in_valid = 1'b1;
    in_addr  = 8'd3;
    in_data  = fill(5, 5);
    in_first = 1'b0;
    @(posedge clk);
    #1;
    chk("midop busy", int'(busy_s), 1);
    in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("midop rst busy", int'(busy_s), 0);
    chk("midop rst sat_flag", int'(sat_flag_s), 0);
    chk("midop rst rd_valid", int'(rd_valid_s), 0);
    chk("midop rst rd_data", lane(rd_data_s, 0), 0);
    mflag_s = 1'b0;
    mflag_w = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    read_grant(3, "midop");
    model_check_entry(3, "midop");

    // Randomised traffic against the model
    for (int i = 0; i < 16; i++) written[i] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        a = $urandom_range(0, 15);
        for (int l = 0; l < 8; l++) begin
          r16 = 16'($urandom_range(0, 65535));
          d[l*16 +: 16] = r16;
        end
        drive_op(32 + a, d, !written[a] || ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
        written[a] = 1'b1;
      end
      if (i % 50 == 49) begin
        idle(2);
        chk($sformatf("rand%0d sat_flag_s", i), int'(sat_flag_s), int'(mflag_s));
        chk($sformatf("rand%0d sat_flag_w", i), int'(sat_flag_w), int'(mflag_w));
        clr_pulse();
        a = $urandom_range(0, 15);
        if (written[a]) begin
          read_grant(32 + a, "rand");
          model_check_entry(32 + a, "rand");
        end
      end
    end
    idle(2);
    for (int i = 0; i < 16; i++) begin
      if (written[i]) begin
        read_grant(32 + i, "final");
        model_check_entry(32 + i, "final");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_accum_mem.md
Name: psum_accum_mem

Overview:
Parametrised partial-sum memory with in-place read-modify-write accumulation. It supersedes the plain write/read pmem array of the current top level.
- Takes per-column psum vectors streamed from the OFIFO/SFU path.
- Either overwrites or accumulates them into an addressed entry, with optional ReLU on the final pass.
- Saturating or wrapping arithmetic is selectable.
- A separate readout port drains results to the testbench or to the next layer.

Parameters:
psum_bw, 16, bit width of one signed psum lane
col, 8, number of lanes per entry
addr_width, 8, address bits; depth = 1<<addr_width entries
SAT, 1, 1 = signed saturating add, 0 = two's-complement wrap

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all control state immediately
in_valid  in  1  accumulate request valid
in_ready  out  1  constant 1; accumulate stream is never back-pressured
in_addr  in  addr_width  target entry
in_data  in  psum_bw*col  signed lanes; lane i = bits [psum_bw*(i+1)-1 : psum_bw*i]
in_first  in  1  1 = overwrite entry with in_data (no read of old value)
in_last  in  1  final pass for this entry; ReLU applied if relu_en
relu_en  in  1  enable ReLU on in_last writes
rd_req  in  1  readout request
rd_ready  out  1  readout grant = !in_valid && !busy (combinational)
rd_addr  in  addr_width  readout entry
rd_valid  out  1  rd_data valid (one-cycle pulse per grant)
rd_data  out  psum_bw*col  readout data
busy  out  1  stage-1 holds an unwritten op
sat_flag  out  1  sticky: some lane saturated (SAT=1) or overflowed (SAT=0)
clr_sat  in  1  synchronous clear of sat_flag

Behaviour:
- Reset values: in_ready=1, busy=0, rd_valid=0, rd_data=0, sat_flag=0, stage-1 valid=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards any in-flight stage-1 write; that entry keeps its prior value.

Two-stage pipeline:
- Edge E0: in_valid captured into stage 1 (addr, data, first, last, relu_en). Old entry value latched into old_q.
- Cycle after E0: combinational compute.
  - sum = first ? in_data : old_q + in_data, per lane.
  - Saturation clamps to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - If last && relu_en, each negative lane is forced to 0, applied after saturation.
- Edge E1: sum written to mem[addr]. Write latency is 2 edges from acceptance.
- Throughput: one op per cycle.

Hazard forwarding:
- At an accepting edge, if stage 1 is valid and in_addr == stage-1 addr, old_q takes the stage-1 sum, not the memory array.
- Back-to-back ops to the same address therefore accumulate correctly with no stall.

Readout:
- On an edge with rd_req && rd_ready, rd_data <= mem[rd_addr] and rd_valid <= 1 for one cycle.
- rd_ready is only high when busy=0, so no write is in flight and no forwarding is needed.
- rd_req while rd_ready=0 is ignored, not queued; the requester holds rd_req.

Flags and edge cases:
- sat_flag sets on the E1 write edge of any lane whose true sum is out of range. This applies in both SAT modes.
- clr_sat and a set on the same edge: the set wins.
- in_first=1 never reads old_q and never sets sat_flag.
- Address wrap is not applicable: addresses are exactly addr_width bits, and every value is a legal entry.

Test Plan:
1. Write/accumulate: in_first=1, addr 5, all lanes 100; 3 cycles later accumulate all lanes 20; then read addr 5 -> rd_data all lanes 120, rd_valid one cycle after grant.
2. Forwarding: consecutive cycles to addr 9 with first=1 data 10, then +5, then +7 (lanes 1-7 data 0) -> read gives lane0=22, lanes 1-7=0, busy deasserts one cycle after the last op.
3. Saturation: SAT=1, first 32000, then +1000 -> 32767 and sat_flag=1; first -32000, then -1000 -> -32768. SAT=0, same first case -> -32536 and sat_flag=1. clr_sat -> sat_flag=0.
4. ReLU: first=1 last=1 relu_en=1, lane0=-50 lane1=30 -> read 0 and 30. Same with relu_en=0 -> -50 and 30.
5. Arbitration: rd_req held while in_valid=1 for 4 cycles -> rd_ready=0 throughout. Grant occurs on the second cycle after in_valid falls (once busy clears), and the read reflects all 4 ops.
6. Reset mid-op: accumulate +5 to addr 3 (old 40), assert reset the cycle after acceptance -> busy=0, sat_flag=0, rd_valid=0 immediately; read after release returns 40.
